// File: rtl/wb_accel_hub.sv
// Wishbone fan-out hub: decodes master address windows onto NR_ACCEL accelerator
// slaves through registered request/response stages, with a watchdog and sticky faults.
module wb_accel_hub #(
  parameter int unsigned       NR_ACCEL  = 2,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       SLOT_BITS = 12,
  parameter int unsigned       TIMEOUT   = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_W-1:0]                m_adr_i,
  input  logic [DATA_W-1:0]                m_dat_i,
  input  logic [DATA_W/8-1:0]              m_sel_i,
  input  logic                             m_we_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  output logic [DATA_W-1:0]                m_dat_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic [NR_ACCEL*ADDR_W-1:0]       s_adr_o,
  output logic [NR_ACCEL*DATA_W-1:0]       s_dat_o,
  output logic [NR_ACCEL*(DATA_W/8)-1:0]   s_sel_o,
  output logic [NR_ACCEL-1:0]              s_we_o,
  output logic [NR_ACCEL-1:0]              s_cyc_o,
  output logic [NR_ACCEL-1:0]              s_stb_o,
  input  logic [NR_ACCEL*DATA_W-1:0]       s_dat_i,
  input  logic [NR_ACCEL-1:0]              s_ack_i,
  input  logic [NR_ACCEL-1:0]              s_err_i,
  output logic [NR_ACCEL-1:0]              fault_o,
  input  logic [NR_ACCEL-1:0]              fault_clr_i,
  output logic                             busy_o
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = (NR_ACCEL > 1) ? $clog2(NR_ACCEL) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  state_e              state, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [SLOT_BITS-1:0] off_q;
  logic [DATA_W-1:0]   wdat_q;
  logic [DATA_W-1:0]   rdat_q;
  logic [SEL_W-1:0]    sel_q;
  logic                we_q;
  logic                ack_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NR_ACCEL-1:0] fault_q;

  logic [ADDR_W-1:0]   rel_adr;
  logic [ADDR_W-1:0]   slot;
  logic                in_range;
  logic                req;

  logic                sel_ack;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_dat;

  logic                go_ack;
  logic                go_err;
  logic                fault_hit;
  logic [NR_ACCEL-1:0] fault_set;

  // Window decode; wrap-around below BASE_ADDR is excluded by the explicit compare.
  assign rel_adr  = m_adr_i - BASE_ADDR;
  assign slot     = rel_adr >> SLOT_BITS;
  assign in_range = (m_adr_i >= BASE_ADDR) && (slot < ADDR_W'(NR_ACCEL));
  assign req      = m_cyc_i & m_stb_i;

  // Slave fan-out is driven purely from registered fields, so the master never
  // reaches a slave combinationally.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = '0;
    s_cyc_o = '0;
    s_stb_o = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NR_ACCEL; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ack = s_ack_i[i];
        sel_err = s_err_i[i];
        sel_dat = s_dat_i[i*DATA_W +: DATA_W];
        if (state == S_REQ) begin
          s_adr_o[i*ADDR_W +: ADDR_W] = ADDR_W'(off_q);
          s_dat_o[i*DATA_W +: DATA_W] = wdat_q;
          s_sel_o[i*SEL_W +: SEL_W]   = sel_q;
          s_we_o[i]  = we_q;
          s_cyc_o[i] = 1'b1;
          s_stb_o[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state;
    go_ack    = 1'b0;
    go_err    = 1'b0;
    fault_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (in_range) begin
            state_d = S_REQ;
          end else begin
            state_d = S_RESP;
            go_err  = 1'b1;
          end
        end
      end
      S_REQ: begin
        // Abort beats any response; err beats ack; any response beats the watchdog.
        if (!m_cyc_i) begin
          state_d = S_IDLE;
        end else if (sel_err) begin
          state_d   = S_RESP;
          go_err    = 1'b1;
          fault_hit = 1'b1;
        end else if (sel_ack) begin
          state_d = S_RESP;
          go_ack  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          go_err    = 1'b1;
          fault_hit = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fault_set = '0;
    for (int i = 0; i < NR_ACCEL; i++) begin
      fault_set[i] = fault_hit && (idx_q == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      off_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      fault_q <= '0;
    end else begin
      if (state == S_IDLE && req && in_range) begin
        idx_q  <= slot[IDX_W-1:0];
        off_q  <= m_adr_i[SLOT_BITS-1:0];
        wdat_q <= m_dat_i;
        sel_q  <= m_sel_i;
        we_q   <= m_we_i;
      end
      cnt_q <= (state == S_REQ && state_d == S_REQ) ? cnt_q + 1'b1 : '0;
      if (go_ack || go_err) begin
        ack_q  <= go_ack;
        rdat_q <= (go_ack && !we_q) ? sel_dat : '0;
      end
      // Set has priority over a simultaneous clear.
      fault_q <= (fault_q & ~fault_clr_i) | fault_set;
    end
  end

  assign m_ack_o = (state == S_RESP) &&  ack_q;
  assign m_err_o = (state == S_RESP) && !ack_q;
  assign m_dat_o = m_ack_o ? rdat_q : '0;
  assign fault_o = fault_q;
  assign busy_o  = (state != S_IDLE);

endmodule

// File: doc/wb_accel_hub.md
Name: wb_accel_hub

Overview:
- Parametrised Wishbone fan-out hub between a compute tile's network-adapter Wishbone master and NR_ACCEL accelerator slaves (SHA-256 and later cores).
- Generalises the single hard-wired accelerator attachment in four ways: address-window decoding, registered request/response stages, a per-transaction watchdog timeout, and sticky per-accelerator fault status.
- Sits between networkadapter_ct wbm_* and the accelerator wb_* ports inside a tile.

Parameters:
- NR_ACCEL, 2, number of accelerator slave ports (1..8).
- DATA_W, 32, Wishbone data width.
- ADDR_W, 32, Wishbone address width.
- BASE_ADDR, 32'h0000_0000, start of accelerator window 0.
- SLOT_BITS, 12, log2 of bytes per accelerator window (4 KiB).
- TIMEOUT, 256, maximum cycles in REQ before the hub forces an error (2..65535).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_adr_i  in  ADDR_W  master address.
- m_dat_i  in  DATA_W  master write data.
- m_sel_i  in  DATA_W/8  byte selects.
- m_we_i  in  1  write enable.
- m_cyc_i  in  1  bus cycle.
- m_stb_i  in  1  strobe.
- m_dat_o  out  DATA_W  read data.
- m_ack_o  out  1  acknowledge.
- m_err_o  out  1  error.
- s_adr_o  out  NR_ACCEL*ADDR_W  per-slave address; offset within window, upper bits zero.
- s_dat_o  out  NR_ACCEL*DATA_W  per-slave write data.
- s_sel_o  out  NR_ACCEL*DATA_W/8  per-slave byte selects.
- s_we_o  out  NR_ACCEL  per-slave write enable.
- s_cyc_o  out  NR_ACCEL  per-slave cycle.
- s_stb_o  out  NR_ACCEL  per-slave strobe.
- s_dat_i  in  NR_ACCEL*DATA_W  per-slave read data.
- s_ack_i  in  NR_ACCEL  per-slave acknowledge.
- s_err_i  in  NR_ACCEL  per-slave error.
- fault_o  out  NR_ACCEL  sticky fault flags: slave error or timeout.
- fault_clr_i  in  NR_ACCEL  clear fault bits, one per slave.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE. Every output is 0: s_* all zero, m_ack_o, m_err_o, m_dat_o, fault_o, busy_o. Timeout counter is 0.
- Decode: idx = (m_adr_i - BASE_ADDR) >> SLOT_BITS. The address is in range iff m_adr_i >= BASE_ADDR and idx < NR_ACCEL. Offset = m_adr_i[SLOT_BITS-1:0].
- Classic single-beat Wishbone only. The master holds stb until ack/err. The hub ignores m_sel_i for decode.
- FSM state IDLE:
  - On m_cyc_i & m_stb_i with the address in range: latch idx, offset, data, sel and we, then go to REQ.
  - On m_cyc_i & m_stb_i out of range: go to RESP with err.
- FSM state REQ:
  - s_cyc_o[idx] and s_stb_o[idx] are 1; the latched fields drive slave idx. All other slaves are held at 0.
  - The counter increments every REQ cycle.
  - On s_ack_i[idx]: capture s_dat_i[idx] and go to RESP with ack.
  - On s_err_i[idx]: go to RESP with err and set fault_o[idx].
  - If the counter reaches TIMEOUT-1 with no response: go to RESP with err and set fault_o[idx]. The slave cyc/stb drop on the same edge.
  - Ack and err in the same cycle: err wins.
  - Response on the final timeout cycle: the response wins and no fault is set.
  - m_cyc_i low in REQ (master abort): slave cyc/stb drop next edge, FSM returns to IDLE, no ack/err, no fault.
  - Ack/err from a non-selected slave is ignored.
- FSM state RESP:
  - Exactly one cycle of m_ack_o or m_err_o; the two are never both 1.
  - m_dat_o holds the captured read data on a read ack; it is 0 on err and on writes.
  - Then unconditionally go to IDLE. The counter is cleared.
- Latency:
  - Slave strobe rises 1 cycle after the master request is sampled.
  - m_ack_o rises 1 cycle after s_ack_i is sampled.
  - Minimum request-to-ack is 3 cycles with a zero-wait slave. Out-of-range error arrives 1 cycle after the request.
  - Back-to-back: a new request is sampled in IDLE; no combinational path from master to slave.
- fault_o: a bit is set by err or timeout on that slave. It is cleared when fault_clr_i is 1. Set and clear in the same cycle: set wins.
- busy_o = (state != IDLE).

Test Plan:
- Write 32'hDEADBEEF to BASE+0x004 with slave 0 acking after 2 wait cycles -> s_adr_o[0]=0x004, s_we_o[0]=1, one m_ack_o pulse 1 cycle after s_ack_i[0], fault_o=0.
- Read BASE+0x1010 with slave 1 returning 32'h6A09E667 -> only slave 1 strobed, s_adr_o[1]=0x010, m_dat_o=32'h6A09E667 with m_ack_o for one cycle.
- Read BASE+0x2000 with NR_ACCEL=2 -> no slave strobed, m_err_o pulse on the cycle after the request, fault_o unchanged.
- Slave 0 never responds, TIMEOUT=16 -> s_cyc_o[0] high for exactly 16 cycles, then m_err_o pulse and fault_o[0]=1. Pulse fault_clr_i[0] -> fault_o[0]=0 next cycle.
- s_ack_i[1] and s_err_i[1] together -> m_err_o=1, m_ack_o=0, fault_o[1]=1. Separately, master drops m_cyc_i after 3 REQ cycles -> slave deasserts next edge, no ack/err.
- Assert rst_n low mid-REQ -> all outputs 0 immediately. After release, a clean write to slave 0 completes in 3 cycles.
